mw8080_banked_memory: RTL and testbench

//  Parametrised CPU memory map for the Midway-Taito 8080 cores: NUM_BANKS ROM banks

---
 rtl/mw8080_banked_memory.sv | 191 +++++++++++++++++++
 tb/tb_mw8080_banked_memory.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mw8080_banked_memory.sv
// -----------------------------------------------------------------------------
// mw8080_banked_memory
//
// CPU memory map for the Midway-Taito 8080 cores: NUM_BANKS ROM banks laid out
// back to back from address 0, plus one work/video RAM. The ROM can be loaded
// at runtime from the MiST ioctl download bus. While a download is running the
// CPU is held off and sees neither ROM data nor RAM writes.
//
// Ports
//   Clock        in   1   system clock, rising edge
//   Reset        in   1   synchronous reset, active-high
//   RW_n         in   1   CPU write strobe (active-low), RAM only
//   Addr         in  16   CPU ROM read address
//   Ram_Addr     in  16   RAM address, low RAM_AW bits used
//   Ram_in       in   8   RAM write data
//   Ram_out      out  8   RAM read data, 1-cycle latency, read-before-write
//   Rom_out      out  8   ROM read data, 1-cycle latency
//   Rom_hit      out  1   Rom_out comes from a populated bank
//   ioctl_downl  in   1   download window active
//   ioctl_wr     in   1   download byte strobe (one cycle)
//   ioctl_addr   in  16   download byte address (same map as Addr)
//   ioctl_dout   in   8   download byte
//   cpu_hold     out  1   CPU stall request while loading
//   dl_done      out  1   last download finished without a reset
//   dl_bytes     out 16   accepted byte count, saturating
//   dl_sum       out  8   modulo-256 sum of accepted bytes
// -----------------------------------------------------------------------------
module mw8080_banked_memory #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_AW   = 11,
  parameter int RAM_AW    = 13
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RW_n,
  input  logic [15:0] Addr,
  input  logic [15:0] Ram_Addr,
  input  logic [7:0]  Ram_in,
  output logic [7:0]  Ram_out,
  output logic [7:0]  Rom_out,
  output logic        Rom_hit,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        cpu_hold,
  output logic        dl_done,
  output logic [15:0] dl_bytes,
  output logic [7:0]  dl_sum
);

  // Bank i lives at i*2**BANK_AW, so the flat ROM index is simply the address.
  localparam int ROM_BYTES = NUM_BANKS * (2 ** BANK_AW);
  localparam int ROM_AW    = (ROM_BYTES > 1) ? $clog2(ROM_BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  logic [7:0] rom_mem [ROM_BYTES];
  logic [7:0] ram_mem [2 ** RAM_AW];

  state_t      state_q, state_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        dl_done_q, dl_done_d;
  logic [15:0] dl_bytes_q, dl_bytes_d;
  logic [7:0]  dl_sum_q, dl_sum_d;
  logic        rom_hit_q, rom_hit_d;
  logic        downl_q;
  logic [7:0]  rom_rd_q;
  logic [7:0]  ram_rd_q;

  logic              downl_rise;
  logic              load_entry;
  logic              rd_in_range;
  logic              wr_in_range;
  logic              rom_we;
  logic              ram_we;
  logic [ROM_AW-1:0] rd_idx;
  logic [ROM_AW-1:0] wr_idx;
  logic [15:0]       bytes_base;
  logic [7:0]        sum_base;

  generate
    if (RAM_AW < 16) begin : g_ram_unused
      logic unused_ram_addr;
      assign unused_ram_addr = ^Ram_Addr[15:RAM_AW];
    end
  endgenerate

  assign rd_in_range = ({16'd0, Addr}       < 32'(ROM_BYTES));
  assign wr_in_range = ({16'd0, ioctl_addr} < 32'(ROM_BYTES));
  // Out-of-range reads are clamped so a non power-of-two bank count never
  // indexes past the end of the array; the hit flag masks the data anyway.
  assign rd_idx      = rd_in_range ? Addr[ROM_AW-1:0] : '0;
  assign wr_idx      = ioctl_addr[ROM_AW-1:0];
  assign downl_rise  = ioctl_downl & ~downl_q;

  always_comb begin
    state_d    = state_q;
    load_entry = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (downl_rise) begin
          state_d    = S_LOAD;
          load_entry = 1'b1;
        end
      end
      S_LOAD: begin
        if (!ioctl_downl) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    cpu_hold_d = (state_d == S_LOAD);

    dl_done_d = dl_done_q;
    if (load_entry) begin
      dl_done_d = 1'b0;
    end else if ((state_q == S_LOAD) && (state_d == S_DONE)) begin
      dl_done_d = 1'b1;
    end

    // A strobe on the very cycle the window opens is accepted, so the write
    // enable covers both the entry cycle and the steady LOAD state.
    rom_we = ioctl_wr & ioctl_downl & wr_in_range & ~Reset &
             (load_entry | (state_q == S_LOAD));

    // Entry restarts the counters before that same cycle's byte is added.
    bytes_base = load_entry ? 16'd0 : dl_bytes_q;
    sum_base   = load_entry ? 8'd0  : dl_sum_q;
    dl_bytes_d = rom_we ? sat_inc16(bytes_base) : bytes_base;
    dl_sum_d   = rom_we ? (sum_base + ioctl_dout) : sum_base;

    // Registered with the array read so data and hit always refer to the
    // same address; uses the next hold value so hold and hit switch together.
    rom_hit_d = rd_in_range & ~cpu_hold_d;

    ram_we = ~RW_n & ~cpu_hold_q;
  end

  // ---- control stage ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cpu_hold_q <= 1'b0;
      dl_done_q  <= 1'b0;
      dl_bytes_q <= 16'd0;
      dl_sum_q   <= 8'd0;
      rom_hit_q  <= 1'b0;
      // Track the live level so a window still open across reset is not
      // mistaken for a fresh rising edge afterwards.
      downl_q    <= ioctl_downl;
    end else begin
      state_q    <= state_d;
      cpu_hold_q <= cpu_hold_d;
      dl_done_q  <= dl_done_d;
      dl_bytes_q <= dl_bytes_d;
      dl_sum_q   <= dl_sum_d;
      rom_hit_q  <= rom_hit_d;
      downl_q    <= ioctl_downl;
    end
  end

  // ---- memory read stage ----
  always_ff @(posedge Clock) begin
    if (rom_we) rom_mem[wr_idx] <= ioctl_dout;
    rom_rd_q <= rom_mem[rd_idx];
  end

  // Read-before-write: the read samples the array before this edge's update.
  always_ff @(posedge Clock) begin
    if (ram_we) ram_mem[Ram_Addr[RAM_AW-1:0]] <= Ram_in;
    ram_rd_q <= ram_mem[Ram_Addr[RAM_AW-1:0]];
  end

  assign Rom_out  = rom_hit_q ? rom_rd_q : 8'h00;
  assign Rom_hit  = rom_hit_q;
  assign Ram_out  = ram_rd_q;
  assign cpu_hold = cpu_hold_q;
  assign dl_done  = dl_done_q;
  assign dl_bytes = dl_bytes_q;
  assign dl_sum   = dl_sum_q;

endmodule

// File: tb/tb_mw8080_banked_memory.sv
module tb_mw8080_banked_memory;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        RW_n;
  logic [15:0] Addr;
  logic [15:0] Ram_Addr;
  logic [7:0]  Ram_in;
  logic [7:0]  Ram_out;
  logic [7:0]  Rom_out;
  logic        Rom_hit;
  logic        ioctl_downl;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        cpu_hold;
  logic        dl_done;
  logic [15:0] dl_bytes;
  logic [7:0]  dl_sum;

  mw8080_banked_memory #(.NUM_BANKS(4), .BANK_AW(11), .RAM_AW(13)) dut (
    .Clock(Clock), .Reset(Reset), .RW_n(RW_n), .Addr(Addr),
    .Ram_Addr(Ram_Addr), .Ram_in(Ram_in), .Ram_out(Ram_out),
    .Rom_out(Rom_out), .Rom_hit(Rom_hit),
    .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_hold(cpu_hold), .dl_done(dl_done),
    .dl_bytes(dl_bytes), .dl_sum(dl_sum)
  );

  always #5 Clock = ~Clock;

  localparam int K_ROM   = 0;
  localparam int K_HIT   = 1;
  localparam int K_RAM   = 2;
  localparam int K_HOLD  = 3;
  localparam int K_DONE  = 4;
  localparam int K_BYTES = 5;
  localparam int K_SUM   = 6;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
    string       name;
  } sb_t;

  sb_t sb[$];
  int  cyc     = 0;
  int  n_total = 0;
  int  n_pass  = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [15:0] actual(input int kind);
    case (kind)
      K_ROM:   return {8'h00, Rom_out};
      K_HIT:   return {15'd0, Rom_hit};
      K_RAM:   return {8'h00, Ram_out};
      K_HOLD:  return {15'd0, cpu_hold};
      K_DONE:  return {15'd0, dl_done};
      K_BYTES: return dl_bytes;
      default: return {8'h00, dl_sum};
    endcase
  endfunction

  // Expectation becomes due after 'lat' further rising edges.
  function automatic void push_exp(input int lat, input int kind,
                                   input logic [15:0] v, input string nm);
    sb_t e;
    e.due  = cyc + lat;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endfunction

  // Monitor: compares every due expectation mid-cycle.
  always @(negedge Clock) begin
    int i;
    logic [15:0] a;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        a = actual(sb[i].kind);
        n_total++;
        if (sb[i].due < cyc) begin
          $display("FAIL %s: check missed its cycle (due %0d, now %0d) got %h required %h",
                   sb[i].name, sb[i].due, cyc, a, sb[i].exp);
        end else if (a !== sb[i].exp) begin
          $display("FAIL %s: got %h required %h (cycle %0d)",
                   sb[i].name, a, sb[i].exp, cyc);
        end else begin
          n_pass++;
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  logic [15:0] dl_addr_t [3] = '{16'h0001, 16'h0002, 16'h0003};
  logic [7:0]  dl_data_t [3] = '{8'h01, 8'h02, 8'hFF};

  initial begin
    Reset = 1'b1; RW_n = 1'b1; Addr = 16'h0000; Ram_Addr = 16'h0000;
    Ram_in = 8'h00; ioctl_downl = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = 16'h0000; ioctl_dout = 8'h00;
    step(); step();
    push_exp(0, K_HOLD,  16'h0, "rst_hold");
    push_exp(0, K_DONE,  16'h0, "rst_done");
    push_exp(0, K_BYTES, 16'h0, "rst_bytes");
    push_exp(0, K_SUM,   16'h0, "rst_sum");
    push_exp(0, K_HIT,   16'h0, "rst_hit");
    push_exp(0, K_ROM,   16'h0, "rst_rom");
    Reset = 1'b0;
    step();

    // Seed RAM locations used later.
    RW_n = 1'b0; Ram_Addr = 16'h0010; Ram_in = 8'h11; step();
    Ram_Addr = 16'h0100; Ram_in = 8'h33; step();
    RW_n = 1'b1;

    // Download with a strobe on the opening cycle.
    ioctl_downl = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 16'h0000; ioctl_dout = 8'h10;
    push_exp(1, K_HOLD,  16'h1,  "entry_hold");
    push_exp(1, K_DONE,  16'h0,  "entry_done");
    push_exp(1, K_BYTES, 16'd1,  "entry_bytes");
    push_exp(1, K_SUM,   16'h10, "entry_sum");
    step();
    for (int k = 0; k < 3; k++) begin
      ioctl_addr = dl_addr_t[k]; ioctl_dout = dl_data_t[k];
      if (k == 2) begin
        push_exp(1, K_BYTES, 16'd4,  "dl4_bytes");
        push_exp(1, K_SUM,   16'h12, "dl4_sum");
        push_exp(1, K_HOLD,  16'h1,  "dl4_hold");
      end
      step();
    end

    // Unpopulated write, blocked RAM write, masked ROM read.
    ioctl_addr = 16'h3000; ioctl_dout = 8'h55;
    RW_n = 1'b0; Ram_Addr = 16'h0010; Ram_in = 8'h77; Addr = 16'h0001;
    push_exp(1, K_BYTES, 16'd4,  "unpop_bytes");
    push_exp(1, K_SUM,   16'h12, "unpop_sum");
    push_exp(1, K_HIT,   16'h0,  "hold_hit");
    push_exp(1, K_ROM,   16'h0,  "hold_rom");
    step();
    RW_n = 1'b1;
    ioctl_addr = 16'h0805; ioctl_dout = 8'hA5;
    push_exp(1, K_BYTES, 16'd5, "b1_bytes");
    push_exp(1, K_SUM,   16'hB7, "b1_sum");
    step();
    ioctl_addr = 16'h0006; ioctl_dout = 8'h3C;
    push_exp(1, K_BYTES, 16'd6, "b0_bytes");
    push_exp(1, K_SUM,   16'hF3, "b0_sum");
    step();

    // Close the window.
    ioctl_wr = 1'b0; ioctl_downl = 1'b0;
    push_exp(1, K_HOLD,  16'h0,  "done_hold");
    push_exp(1, K_DONE,  16'h1,  "done_flag");
    push_exp(1, K_BYTES, 16'd6,  "done_bytes");
    push_exp(1, K_SUM,   16'hF3, "done_sum");
    push_exp(1, K_RAM,   16'h11, "ram_blocked");
    step();

    // Bank switch without a mixed byte.
    Addr = 16'h0805;
    push_exp(1, K_ROM, 16'hA5, "rom_0805");
    push_exp(1, K_HIT, 16'h1,  "hit_0805");
    step();
    Addr = 16'h0006;
    push_exp(1, K_ROM, 16'h3C, "rom_0006");
    push_exp(1, K_HIT, 16'h1,  "hit_0006");
    step();
    Addr = 16'h0003; push_exp(1, K_ROM, 16'hFF, "rom_0003"); step();
    Addr = 16'h0000; push_exp(1, K_ROM, 16'h10, "rom_0000"); step();

    // Unpopulated and last populated bank.
    Addr = 16'h2000;
    push_exp(1, K_ROM, 16'h0, "rom_2000");
    push_exp(1, K_HIT, 16'h0, "hit_2000");
    step();
    Addr = 16'h1FFF; push_exp(1, K_HIT, 16'h1, "hit_1fff"); step();

    // Strobe outside the window is ignored.
    ioctl_wr = 1'b1; ioctl_addr = 16'h0000; ioctl_dout = 8'hEE;
    push_exp(1, K_BYTES, 16'd6, "idle_wr_bytes");
    push_exp(1, K_DONE,  16'h1, "idle_wr_done");
    step();
    ioctl_wr = 1'b0; Addr = 16'h0000;
    push_exp(1, K_ROM, 16'h10, "idle_wr_rom");
    step();

    // RAM read-during-write returns old data.
    RW_n = 1'b0; Ram_Addr = 16'h0100; Ram_in = 8'h5A;
    push_exp(1, K_RAM, 16'h33, "ram_rdw_old");
    step();
    RW_n = 1'b1;
    push_exp(1, K_RAM, 16'h5A, "ram_new");
    step();

    // DONE -> LOAD, then reset mid-load.
    ioctl_downl = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 16'h0200; ioctl_dout = 8'hC1;
    push_exp(1, K_HOLD,  16'h1,  "reload_hold");
    push_exp(1, K_DONE,  16'h0,  "reload_done");
    push_exp(1, K_BYTES, 16'd1,  "reload_bytes");
    push_exp(1, K_SUM,   16'hC1, "reload_sum");
    step();
    ioctl_addr = 16'h0201; ioctl_dout = 8'hC2;
    push_exp(1, K_BYTES, 16'd2,  "reload2_bytes");
    push_exp(1, K_SUM,   16'h83, "reload2_sum");
    step();
    ioctl_wr = 1'b0; Reset = 1'b1;
    push_exp(1, K_HOLD,  16'h0, "midrst_hold");
    push_exp(1, K_DONE,  16'h0, "midrst_done");
    push_exp(1, K_BYTES, 16'd0, "midrst_bytes");
    push_exp(1, K_SUM,   16'h0, "midrst_sum");
    step();
    Reset = 1'b0;
    push_exp(1, K_HOLD, 16'h0, "post_rst_hold");
    step();
    ioctl_downl = 1'b0; Addr = 16'h0200;
    push_exp(1, K_ROM,  16'hC1, "rom_0200");
    push_exp(1, K_HIT,  16'h1,  "hit_0200");
    push_exp(1, K_DONE, 16'h0,  "post_rst_done");
    step();
    Addr = 16'h0201; push_exp(1, K_ROM, 16'hC2, "rom_0201"); step();

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 20 && sb.size() > 0; w++) step();
    while (sb.size() > 0) begin
      n_total++;
      $display("FAIL %s: never checked, required %h", sb[0].name, sb[0].exp);
      sb.delete(0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
